mdu_seq: RTL and testbench
==========================

# mdu_seq

Iterative multiply/divide sequencer for the pipelined CPU. It owns a dedicated instance of the 32-bit ALU, which provides add and subtract with no carry-out. It drives that ALU for 32 iterations to produce 64-bit MULT/MULTU products and DIV/DIVU quotient/remainder pairs into HI/LO. It sits beside the EX stage; the pipeline stalls on `busy` and reads `hi`/`lo` after `done`.

## Interface
Parameters: none (widths fixed at 32).

Ports:
- `clock`  in  1  rising-edge clock
- `resetn`  in  1  reset, synchronous, active-low
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- `rs`  in  32  multiplicand / dividend
- `rt`  in  32  multiplier / divisor
- `cancel`  in  1  pipeline flush; aborts the operation in flight
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle on
- `hi`  out  32  HI result (product high word / remainder)
- `lo`  out  32  LO result (product low word / quotient)
- `alu_a`  out  32  ALU operand a
- `alu_b`  out  32  ALU operand b
- `alu_aluc`  out  3  ALU control: 3'b000 ADD, 3'b100 SUB
- `alu_r`  in  32  ALU result

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- **IDLE**
  - `start=1` latches `op`, the operand magnitudes (the absolute value for signed ops) and the result-sign flags, then goes to PREP.
  - `start=0` stays in IDLE.
  - `start` is ignored outside IDLE.
- **PREP** (one cycle)
  - Clears the 64-bit accumulator {H,L}: multiply gives H=0, L=|rt|; divide gives H=0, L=|rs|.
  - Clears the 5-bit counter.
  - Divide with divisor 0 goes straight to DONE with `hi`=rs (raw) and `lo`=32'hFFFFFFFF. No sign fix is applied.
  - Otherwise goes to ITER.
- **ITER**, multiply step (32 cycles)
  - `alu_a`=H, `alu_b`= L[0] ? |rs| : 0, `alu_aluc`=ADD.
  - carry = (a31&b31) | ((a31|b31)&~r31).
  - {H,L} <= {carry, alu_r, L} >> 1.
- **ITER**, divide step (restoring)
  - `alu_a`={H[30:0],L[31]}, `alu_b`=|rt|, `alu_aluc`=SUB.
  - borrow = (~a31&b31) | (~(a31^b31)&r31).
  - ge = H[31] | ~borrow.
  - H <= ge ? alu_r : alu_a; L <= {L[30:0], ge}.
- **ITER** exit: when the counter reaches 31, go to FIX.
- **FIX** (one cycle)
  - MULT: negate the 64-bit {H,L} if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Unsigned ops pass through unchanged.
  - Copy the result into `hi`/`lo`.
- **DONE**: assert `done` and `busy`; next state is IDLE.
- Outside ITER, `alu_a`, `alu_b` and `alu_aluc` are 0.
- **cancel**
  - In PREP, ITER or FIX: next state is IDLE; `hi`/`lo` keep their previous values; `done` is not asserted.
  - In IDLE, `cancel` has no effect.
  - In DONE, the result is already committed; `cancel` has no effect.
- DIV 0x80000000 / -1 gives `lo`=0x80000000 and `hi`=0, with no exception.
- Reset mid-operation: the next state is IDLE and every output returns to its reset value.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `alu_a`=0, `alu_b`=0, `alu_aluc`=0.
- With `start` sampled at edge T:
  - PREP occupies cycle T+1.
  - ITER occupies T+2 .. T+33.
  - FIX occupies T+34.
  - `done` is high in cycle T+35.
- Divide by zero: `done` is high in cycle T+2.
- `start` is accepted again in the cycle after `done`, so back-to-back operations are spaced 36 cycles apart.
- The ALU path is combinational within one cycle: state → `alu_a`/`alu_b` → `alu_r` → accumulator register.

## Configuration
- `MDU_DIV_EN` defined: DIVU/DIV are implemented as above.
- `MDU_DIV_EN` undefined:
  - The divide datapath is removed.
  - A divide `op` goes PREP → DONE with `hi`=0 and `lo`=0.
  - `done` is asserted at T+2.
  - Multiply is unchanged.

## Structure
- Package `mdu_pkg` holds:
  - the `op` encoding constants;
  - the state enum;
  - `ALUC_ADD`=3'b000 and `ALUC_SUB`=3'b100;
  - `MDU_ITERS`=32.
- Sub-module `mdu_fix`: combinational 64-bit conditional negator, also used for the operand absolute values in IDLE.
- The ALU instance sits outside this block, wired to the `alu_*` ports.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=FFFFFFFE, `lo`=00000001, `done` at T+35, `busy` high T+1..T+35.
- MULT −3 × 7 → `hi`=FFFFFFFF, `lo`=FFFFFFEB. MULT 0x80000000 × 0x80000000 → `hi`=40000000, `lo`=0.
- DIV −7 / 2 → `lo`=FFFFFFFD, `hi`=FFFFFFFF. DIVU 100 / 7 → `lo`=0000000E, `hi`=00000002.
- DIVU 100 / 0 → `hi`=00000064, `lo`=FFFFFFFF, `done` at T+2. DIV 0x80000000 / −1 → `lo`=80000000, `hi`=0.
- MULT started, then `cancel` at T+10 → IDLE at T+11, no `done`, `hi`/`lo` keep prior result; a new `start` is accepted at T+11.
- `start` pulsed while busy → ignored; `resetn`=0 at T+20 → all outputs 0 at T+21.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings, widths and state enum for the multiply/divide sequencer.
package mdu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MDU_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(MDU_ITERS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_ITERS - 1);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

  // Operation context captured when a request is accepted.
  typedef struct packed {
    logic [1:0]      op;
    logic            neg_res;
    logic            neg_rem;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
  } mdu_ctx_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/response bundle between the EX stage and the sequencer.
interface mdu_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs, rt, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, rs, rt, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_fix.sv
// mdu_fix: combinational two's-complement conditional negator.
module mdu_fix #(
  parameter int unsigned W = 64
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = neg ? (~x + W'(1)) : x;
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: 32-iteration multiply/divide sequencer driving an external add/sub ALU.
// Build option: define MDU_DIV_EN to include the restoring divider; without it
// DIVU/DIV complete right after PREP with hi = lo = 0.
module mdu_seq
  import mdu_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  mdu_seq_if.slave          bus,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [2:0]        alu_aluc,
  input  logic [XLEN-1:0]   alu_r
);

  mdu_state_e      state_q, state_d;
  mdu_ctx_t        ctx_q;
  logic [XLEN-1:0] acc_h_q, acc_l_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] step_h, step_l;
  logic            mul_carry;
  logic            div_short;
  logic            fix_sel;
  logic [XLEN-1:0] fix_lo_y, fix_hi_y;
  logic [2*XLEN-1:0] prod_y;
`ifdef MDU_DIV_EN
  logic [XLEN-1:0] rs_raw_q;
  logic            div_borrow, div_ge;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Negators are shared: operand magnitudes in IDLE, quotient/remainder sign fix in FIX.
  assign fix_sel = (state_q == S_FIX);

  mdu_fix #(.W(XLEN)) u_fix_lo (
    .neg (fix_sel ? ctx_q.neg_res : (op_is_signed(bus.op) & bus.rs[XLEN-1])),
    .x   (fix_sel ? acc_l_q : bus.rs),
    .y   (fix_lo_y)
  );

  mdu_fix #(.W(XLEN)) u_fix_hi (
    .neg (fix_sel ? ctx_q.neg_rem : (op_is_signed(bus.op) & bus.rt[XLEN-1])),
    .x   (fix_sel ? acc_h_q : bus.rt),
    .y   (fix_hi_y)
  );

  mdu_fix #(.W(2*XLEN)) u_fix_prod (
    .neg (ctx_q.neg_res),
    .x   ({acc_h_q, acc_l_q}),
    .y   (prod_y)
  );

`ifdef MDU_DIV_EN
  assign div_short = op_is_div(ctx_q.op) && (ctx_q.mag_b == '0);
`else
  assign div_short = op_is_div(ctx_q.op);
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; cancel aborts anything between acceptance and commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_PREP;
      S_PREP: begin
        if (bus.cancel)     state_d = S_IDLE;
        else if (div_short) state_d = S_DONE;
        else                state_d = S_ITER;
      end
      S_ITER: begin
        if (bus.cancel)              state_d = S_IDLE;
        else if (cnt_q == CNT_LAST)  state_d = S_FIX;
      end
      S_FIX:  state_d = bus.cancel ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU operand drive; idle (all zero) outside ITER.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_aluc = ALUC_ADD;
    if (state_q == S_ITER) begin
      alu_a = acc_h_q;
      alu_b = acc_l_q[0] ? ctx_q.mag_a : '0;
`ifdef MDU_DIV_EN
      if (op_is_div(ctx_q.op)) begin
        alu_a    = {acc_h_q[XLEN-2:0], acc_l_q[XLEN-1]};
        alu_b    = ctx_q.mag_b;
        alu_aluc = ALUC_SUB;
      end
`endif
    end
  end

  // One shift-add or restoring-subtract step, carry/borrow rebuilt from sign bits.
  always_comb begin
    mul_carry = (alu_a[XLEN-1] & alu_b[XLEN-1]) |
                ((alu_a[XLEN-1] | alu_b[XLEN-1]) & ~alu_r[XLEN-1]);
    step_h = {mul_carry, alu_r[XLEN-1:1]};
    step_l = {alu_r[0], acc_l_q[XLEN-1:1]};
`ifdef MDU_DIV_EN
    div_borrow = (~alu_a[XLEN-1] & alu_b[XLEN-1]) |
                 (~(alu_a[XLEN-1] ^ alu_b[XLEN-1]) & alu_r[XLEN-1]);
    div_ge     = acc_h_q[XLEN-1] | ~div_borrow;
    if (op_is_div(ctx_q.op)) begin
      step_h = div_ge ? alu_r : alu_a;
      step_l = {acc_l_q[XLEN-2:0], div_ge};
    end
`endif
  end

  // Operand capture, accumulator/counter, and HI/LO commit.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ctx_q   <= '0;
      acc_h_q <= '0;
      acc_l_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_DIV_EN
      rs_raw_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          ctx_q.op      <= bus.op;
          ctx_q.neg_res <= op_is_signed(bus.op) & (bus.rs[XLEN-1] ^ bus.rt[XLEN-1]);
          ctx_q.neg_rem <= op_is_signed(bus.op) & bus.rs[XLEN-1];
          ctx_q.mag_a   <= fix_lo_y;
          ctx_q.mag_b   <= fix_hi_y;
`ifdef MDU_DIV_EN
          rs_raw_q      <= bus.rs;
`endif
        end
        S_PREP: begin
          acc_h_q <= '0;
          acc_l_q <= op_is_div(ctx_q.op) ? ctx_q.mag_a : ctx_q.mag_b;
          cnt_q   <= '0;
          if (!bus.cancel && div_short) begin
`ifdef MDU_DIV_EN
            hi_q <= rs_raw_q;
            lo_q <= '1;
`else
            hi_q <= '0;
            lo_q <= '0;
`endif
          end
        end
        S_ITER: begin
          acc_h_q <= step_h;
          acc_l_q <= step_l;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        S_FIX: if (!bus.cancel) begin
          if (op_is_div(ctx_q.op)) begin
            hi_q <= fix_hi_y;
            lo_q <= fix_lo_y;
          end else begin
            hi_q <= prod_y[2*XLEN-1:XLEN];
            lo_q <= prod_y[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // busy spans acceptance through DONE; done is the DONE-state pulse.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq with a behavioural add/sub ALU attached.
module tb_mdu_seq;
  import mdu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic [2:0]  aluc;
    int          t0;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [2:0]  alu_aluc;
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  exp_t        sb_q[$];

  mdu_seq_if bus ();

  mdu_seq dut (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_aluc (alu_aluc),
    .alu_r    (alu_r)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // External ALU: add or subtract, no carry-out.
  always_comb alu_r = (alu_aluc == 3'b100) ? (alu_a - alu_b) : (alu_a + alu_b);

  // Reference results computed with wide integer arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, q, r;
    logic [63:0] p;
    e.name = ""; e.hi = '0; e.lo = '0; e.lat = 35; e.aluc = 3'b000; e.t0 = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
`ifdef MDU_DIV_EN
        e.aluc = 3'b100;
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFFFFFF; e.lat = 2;
        end else if (op == 2'b10) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          e.lo = 32'(q); e.hi = 32'(r);
        end
`else
        e.hi = '0; e.lo = '0; e.lat = 2;
`endif
      end
    endcase
    return e;
  endfunction

  // Pulse start for one cycle; returns at #1 after the accepting edge (cycle T+1).
  task automatic start_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit score);
    exp_t e;
    bus.op = op; bus.rs = a; bus.rt = b; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    if (score) begin
      e = model(op, a, b);
      e.name = name;
      e.t0 = cyc;
      sb_q.push_back(e);
    end
  endtask

  // Wait (bounded) for done, pop the scoreboard and compare; ends in the cycle after done.
  task automatic collect();
    exp_t e;
    int n;
    bit seen, busy_ok;
    seen = 1'b0; busy_ok = 1'b1;
    if (sb_q.size() == 0) begin
      checks++;
      $display("FAIL collect: scoreboard empty");
      return;
    end
    e = sb_q[0];
    for (int k = 0; k < 64; k++) begin
      if (bus.done === 1'b1) begin seen = 1'b1; break; end
      n = cyc - e.t0 + 1;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (n == 1) begin
        checks++;
        if ({alu_a, alu_b, alu_aluc} !== 67'd0)
          $display("FAIL %s alu_prep: got a=%h b=%h c=%b want zeros", e.name, alu_a, alu_b, alu_aluc);
        else passed++;
      end
      if (n == 2 && e.lat == 35) begin
        checks++;
        if (alu_aluc !== e.aluc) $display("FAIL %s alu_aluc: got %b want %b", e.name, alu_aluc, e.aluc);
        else passed++;
      end
      @(posedge clock); #1;
    end
    e = sb_q.pop_front();
    n = cyc - e.t0 + 1;
    checks++;
    if (!seen) begin
      $display("FAIL %s timeout: done not seen, got cycle %0d want %0d", e.name, n, e.lat);
      return;
    end
    passed++;
    checks++;
    if (bus.hi !== e.hi) $display("FAIL %s hi: got %h want %h", e.name, bus.hi, e.hi);
    else passed++;
    checks++;
    if (bus.lo !== e.lo) $display("FAIL %s lo: got %h want %h", e.name, bus.lo, e.lo);
    else passed++;
    checks++;
    if (n !== e.lat) $display("FAIL %s latency: got T+%0d want T+%0d", e.name, n, e.lat);
    else passed++;
    checks++;
    if (!busy_ok || bus.busy !== 1'b1)
      $display("FAIL %s busy: got gap=%0b/done-cycle=%b want continuous 1", e.name, !busy_ok, bus.busy);
    else passed++;
    @(posedge clock); #1;
    checks++;
    if ({bus.done, bus.busy} !== 2'b00)
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", e.name, bus.done, bus.busy);
    else passed++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    checks++;
    if ({bus.busy, bus.done, bus.hi, bus.lo, alu_a, alu_b, alu_aluc} !== 133'd0)
      $display("FAIL reset_values: got busy=%b done=%b hi=%h lo=%h a=%h b=%h c=%b want all 0",
               bus.busy, bus.done, bus.hi, bus.lo, alu_a, alu_b, alu_aluc);
    else passed++;
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_mult();
    start_op("multu_ff", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); collect();
    start_op("mult_m3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b1); collect();
    start_op("mult_min2", OP_MULT, 32'h80000000, 32'h80000000, 1'b1); collect();
    start_op("mult_maxmin", OP_MULT, 32'h7FFFFFFF, 32'h80000000, 1'b1); collect();
    start_op("multu_zero", OP_MULTU, 32'd0, 32'h12345678, 1'b1); collect();
    for (int i = 0; i < 3; i++) begin
      start_op("mult_rand", 2'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
      collect();
    end
  endtask

  task automatic test_div();
    logic [31:0] d;
    start_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1); collect();
    start_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b1); collect();
    start_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 1'b1); collect();
    start_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1); collect();
    start_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b1); collect();
    start_op("div_m1_by0", OP_DIV, 32'hFFFFFFFF, 32'd0, 1'b1); collect();
    start_op("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 1'b1); collect();
    for (int i = 0; i < 3; i++) begin
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      start_op("div_rand", 2'($urandom_range(2, 3)), $urandom, d, 1'b1);
      collect();
    end
  endtask

  task automatic test_ignore_start();
    start_op("ignore_keep", OP_MULTU, 32'd1000, 32'd3000, 1'b1);
    repeat (3) begin @(posedge clock); #1; end
    bus.op = OP_DIVU; bus.rs = 32'd55; bus.rt = 32'd0; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    collect();
  endtask

  task automatic test_cancel();
    exp_t prior;
    prior = model(OP_MULT, 32'd12345, 32'hFFFFFD4A);
    start_op("cancel_prior", OP_MULT, 32'd12345, 32'hFFFFFD4A, 1'b1); collect();
    start_op("cancel_victim", OP_MULT, 32'd7, 32'd9, 1'b0);
    repeat (9) begin @(posedge clock); #1; end
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL cancel_busy_T10: got %b want 1", bus.busy);
    else passed++;
    bus.cancel = 1'b1;
    @(posedge clock); #1;
    bus.cancel = 1'b0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL cancel_idle_T11: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    else passed++;
    checks++;
    if ({bus.hi, bus.lo} !== {prior.hi, prior.lo})
      $display("FAIL cancel_hold: got %h_%h want %h_%h", bus.hi, bus.lo, prior.hi, prior.lo);
    else passed++;
    start_op("cancel_next", OP_MULTU, 32'hDEADBEEF, 32'h00010001, 1'b1);
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL cancel_restart: got busy=%b want 1", bus.busy);
    else passed++;
    collect();
  endtask

  task automatic test_reset_mid();
    start_op("reset_victim", OP_MULT, 32'hFFFF0001, 32'h00007777, 1'b0);
    repeat (19) begin @(posedge clock); #1; end
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    checks++;
    if ({bus.busy, bus.done, bus.hi, bus.lo, alu_a, alu_b, alu_aluc} !== 133'd0)
      $display("FAIL reset_mid_T21: got busy=%b done=%b hi=%h lo=%h a=%h b=%h c=%b want all 0",
               bus.busy, bus.done, bus.hi, bus.lo, alu_a, alu_b, alu_aluc);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      start_op("b2b", 2'($urandom_range(0, 3)), $urandom, 32'($urandom_range(0, 70000)), 1'b1);
      collect();
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 2'b00; bus.rs = '0; bus.rt = '0;
    test_reset();
    test_mult();
    test_div();
    test_ignore_start();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
